// File: rtl/sram_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sram_controller
// Single-port controller for one external 1M x 32 asynchronous SRAM.
// Accepts a held load/store request from the crossbar, sequences
// CE#/OE#/WE#/BE# with WAIT_CYCLES of access time, and owns the tri-state
// data bus. Every pad output is a flop loaded from the next-state decode.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   load, store           read / write request, held until busy seen low
//   addr                  byte address, SRAM word address = addr[21:2]
//   wdata, byte_en        write data and byte enables (bit i = byte i)
//   rdata                 registered read data, valid when busy drops
//   busy                  request in progress (combinational)
//   ram_data              SRAM data bus (bidirectional)
//   ram_addr, ram_be_n    SRAM word address, active-low byte enables
//   ram_ce_n, ram_oe_n,
//   ram_we_n              SRAM strobes, active-low
// -----------------------------------------------------------------------------
module sram_controller #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        store,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  byte_en,
   output logic [31:0] rdata,
   output logic        busy,
   inout  wire  [31:0] ram_data,
   output logic [19:0] ram_addr,
   output logic [3:0]  ram_be_n,
   output logic        ram_ce_n,
   output logic        ram_oe_n,
   output logic        ram_we_n
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ACCESS,
      S_RD_DONE,
      S_WR_SETUP,
      S_WR_PULSE,
      S_WR_HOLD,
      S_WR_DONE
   } state_t;

   localparam logic [2:0] LP_CNT_LOAD = 3'(WAIT_CYCLES - 1);

   state_t      r_state;
   state_t      w_next;
   logic        w_busy;
   logic        w_capture;
   logic        w_rd_hit;
   logic        w_cnt_reload;
   logic [2:0]  r_cnt;
   logic [31:0] r_rdata;
   logic [31:0] r_wdata;
   logic [19:0] r_ram_addr;
   logic [3:0]  r_be_n;
   logic        r_ce_n;
   logic        r_oe_n;
   logic        r_we_n;
   logic        r_drive;
   logic        w_unused_addr;

   // Only addr[21:2] selects a word inside the 4 MB chip.
   assign w_unused_addr = ^{addr[31:22], addr[1:0]};

   always_comb begin
      w_next = r_state;
      w_busy = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_busy = load | store;
            if (load)       w_next = S_RD_ACCESS;
            else if (store) w_next = S_WR_SETUP;
         end
         S_RD_ACCESS: begin
            w_busy = 1'b1;
            // Requester withdrew the load (fetch flush): abandon quietly.
            if (!load)              w_next = S_IDLE;
            else if (r_cnt == 3'd0) w_next = S_RD_DONE;
         end
         S_RD_DONE:  w_next = S_IDLE;
         S_WR_SETUP: begin
            w_busy = 1'b1;
            w_next = S_WR_PULSE;
         end
         S_WR_PULSE: begin
            w_busy = 1'b1;
            if (r_cnt == 3'd0) w_next = S_WR_HOLD;
         end
         S_WR_HOLD: begin
            w_busy = 1'b1;
            w_next = S_WR_DONE;
         end
         S_WR_DONE:  w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
      if (rst) w_busy = 1'b0;
   end

   assign w_capture    = (r_state == S_IDLE) && (w_next != S_IDLE);
   assign w_rd_hit     = (r_state == S_RD_ACCESS) && (w_next == S_RD_DONE);
   assign w_cnt_reload = ((w_next == S_RD_ACCESS) && (r_state != S_RD_ACCESS)) ||
                         ((w_next == S_WR_PULSE)  && (r_state != S_WR_PULSE));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= 3'd0;
         r_rdata    <= 32'd0;
         r_ram_addr <= 20'd0;
         r_be_n     <= 4'b0000;
         r_ce_n     <= 1'b1;
         r_oe_n     <= 1'b1;
         r_we_n     <= 1'b1;
         r_drive    <= 1'b0;
      end else begin
         r_state <= w_next;
         // Strobes are decoded from the state being entered so the pads
         // change only on the clock edge.
         r_ce_n  <= !(w_next inside {S_RD_ACCESS, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
         r_oe_n  <= !(w_next == S_RD_ACCESS);
         r_we_n  <= !(w_next == S_WR_PULSE);
         r_drive <= w_next inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD};
         if (w_capture) begin
            r_ram_addr <= addr[21:2];
            r_be_n     <= load ? 4'b0000 : ~byte_en;
         end
         if (w_rd_hit) r_rdata <= ram_data;
         if (w_cnt_reload)        r_cnt <= LP_CNT_LOAD;
         else if (r_cnt != 3'd0)  r_cnt <= r_cnt - 3'd1;
      end
   end

   // Write data needs no reset: it only reaches the bus while r_drive is set.
   always_ff @(posedge clk) begin
      if (w_capture) r_wdata <= wdata;
   end

   assign ram_data = r_drive ? r_wdata : 32'bz;
   assign rdata    = r_rdata;
   assign busy     = w_busy;
   assign ram_addr = r_ram_addr;
   assign ram_be_n = r_be_n;
   assign ram_ce_n = r_ce_n;
   assign ram_oe_n = r_oe_n;
   assign ram_we_n = r_we_n;

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Single-port controller for one external 32-bit asynchronous SRAM chip (BaseRAM or ExtRAM, 4 MB, 1M x 32). Two instances are used.
- Sits directly downstream of the bus crossbar. It takes the crossbar's load/store/addr/wdata/byte_en request and returns rdata/busy.
- It sequences the SRAM pins (CE#/OE#/WE#/BE#) with a parameterised access time.
- It owns the tri-state data bus.

Parameters:
WAIT_CYCLES, 1, cycles OE#/WE# is held low per access (legal 1..7); sized for SRAM access time at clk.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
load  in  1  read request; held by requester until busy seen low
store  in  1  write request; held until busy seen low
addr  in  32  byte address; SRAM word address = addr[21:2]
wdata  in  32  write data
byte_en  in  4  write byte enables, bit i = byte i
rdata  out  32  read data, registered
busy  out  1  request in progress
ram_data  inout  32  SRAM data bus
ram_addr  out  20  SRAM word address
ram_be_n  out  4  SRAM byte enables, active-low
ram_ce_n  out  1  chip enable, active-low
ram_oe_n  out  1  output enable, active-low
ram_we_n  out  1  write enable, active-low

Behaviour:
- Reset and clocking:
  - Reset is rst, synchronous, active-high; clock is clk.
  - Reset values: rdata=0, ram_addr=0, ram_be_n=4'b0000, ram_ce_n=1, ram_oe_n=1, ram_we_n=1, ram_data=Z, state=IDLE.
  - busy=0 while rst is high.
- Pin outputs:
  - All pin outputs are flops loaded from next-state decode. The values listed per state hold for every cycle spent in that state. No combinational glitches reach the pads.
- Request capture:
  - addr[21:2], wdata and ~byte_en are latched on the IDLE->access transition.
  - Later changes on the request inputs are ignored for the rest of the access.
  - On reads, ram_be_n=4'b0000; the full word is always returned.
- busy (combinational):
  - IDLE: busy = load|store.
  - RD_DONE and WR_DONE: busy = 0.
  - All other states: busy = 1.
  - The requester samples rdata in the same cycle busy is low with load high. In that cycle rdata is already valid.
- State machine:
  - IDLE: pins inactive, ram_data=Z.
    - load -> RD_ACCESS.
    - else store -> WR_SETUP.
    - load has priority if both are high.
  - RD_ACCESS: ce_n=0, oe_n=0, ram_data=Z. A counter counts WAIT_CYCLES cycles.
    - On the last cycle, the edge captures ram_data into rdata and goes to RD_DONE.
    - If load drops before that (fetch flush), go to IDLE without updating rdata.
  - RD_DONE: ce_n=1, oe_n=1. rdata holds. -> IDLE.
  - WR_SETUP (1 cycle): ce_n=0, we_n=1, oe_n=1, ram_data driven with wdata. -> WR_PULSE.
  - WR_PULSE: WAIT_CYCLES cycles, we_n=0, data driven. -> WR_HOLD.
  - WR_HOLD (1 cycle): we_n=1, ce_n=0, data still driven. -> WR_DONE.
  - WR_DONE: ce_n=1, ram_data=Z. -> IDLE.
- Write abort: writes are never aborted. Once accepted they complete even if store drops.
- Latency, from the request cycle in IDLE to the busy-low cycle:
  - Read: WAIT_CYCLES+1 cycles.
  - Write: WAIT_CYCLES+3 cycles.
  - With WAIT_CYCLES=1, read busy-low falls in cycle 2 and write busy-low in cycle 4.
- Back-to-back requests: a request present in the cycle after *_DONE (state IDLE) starts immediately. There is no mandatory dead cycle beyond the DONE state.
- Bus contention: ram_data is never driven while oe_n=0. oe_n stays 1 in every write state.
- Reset mid-operation: all pins return to their reset values at the reset edge. No partial write pulse is extended. busy returns to 0.
- Counter: 3 bits. It reloads on entry to RD_ACCESS or WR_PULSE and never wraps past WAIT_CYCLES.

Test Plan:
- Read with WAIT_CYCLES=1: load=1, addr=0x8000_0010, SRAM model returns 0xDEADBEEF at word 4.
  -> ram_addr=4, oe_n/ce_n low for 1 cycle, busy low in cycle 2, rdata=0xDEADBEEF that cycle.
- Byte write: store, addr=0x8000_0020, wdata=0x11223344, byte_en=4'b0100.
  -> ram_be_n=4'b1011, we_n low exactly 1 cycle, data stable from WR_SETUP through WR_HOLD, busy low in cycle 4.
  -> A follow-up read of word 8 returns the old word with byte 2 = 0x22.
- Read abort: load drops during RD_ACCESS with WAIT_CYCLES=3.
  -> IDLE next cycle, pins inactive, rdata unchanged (still the previous value).
- Simultaneous load=1, store=1.
  -> Read performed, we_n never asserted, ram_data stays Z.
- Reset asserted in WR_PULSE.
  -> Next edge: we_n=1, ce_n=1, ram_data=Z, busy=0, rdata=0; a new read then completes normally.
- Back-to-back: write to 0x807F_FFFC then immediate read of the same address.
  -> ram_addr=0xFFFFF, read returns the written word, at most 1 IDLE cycle between accesses, no cycle with oe_n=0 and ram_data driven.
